// File: rtl/universal_shift_reg.sv
// Parametrised universal shift register: hold/shift/rotate/arith-shift/load/clear,
// usable one step at a time or as a self-timed burst of N operations.
module universal_shift_reg #(
    parameter int WIDTH = 8,
    parameter int AMT_W = 4
) (
    input  logic             i_clk,
    input  logic             i_rst,
    input  logic             i_en,
    input  logic             i_start,
    input  logic [2:0]       i_mode,
    input  logic [AMT_W-1:0] i_amt,
    input  logic [WIDTH-1:0] i_d,
    input  logic             i_sin,
    output logic [WIDTH-1:0] o_q,
    output logic             o_sout,
    output logic             o_busy,
    output logic             o_done
);

    typedef enum logic [1:0] {IDLE, RUN, DONE} state_t;

    state_t           state_reg;
    logic [2:0]       mode_reg;
    logic [AMT_W-1:0] cnt_reg;
    logic [WIDTH-1:0] q_reg;
    logic             sout_reg;
    logic             busy_reg;
    logic             done_reg;

    logic [2:0]       op_mode;
    logic             op_fire;
    logic [WIDTH-1:0] q_next;
    logic             sout_next;

    logic [WIDTH-1:0] shr_q, shl_q, ror_q, rol_q, asr_q;

    // Per-bit neighbour selection for the five shift-class results.
    genvar gi;
    generate
        for (gi = 0; gi < WIDTH; gi++) begin : g_bit
            if (gi == WIDTH - 1) begin : g_top
                assign shr_q[gi] = i_sin;
                assign ror_q[gi] = q_reg[0];
                assign asr_q[gi] = q_reg[WIDTH-1];
            end else begin : g_hi
                assign shr_q[gi] = q_reg[gi+1];
                assign ror_q[gi] = q_reg[gi+1];
                assign asr_q[gi] = q_reg[gi+1];
            end
            if (gi == 0) begin : g_bot
                assign shl_q[gi] = i_sin;
                assign rol_q[gi] = q_reg[WIDTH-1];
            end else begin : g_lo
                assign shl_q[gi] = q_reg[gi-1];
                assign rol_q[gi] = q_reg[gi-1];
            end
        end
    endgenerate

    // A burst replays its latched mode; single steps use the live mode.
    always_comb begin
        op_mode = (state_reg == RUN) ? mode_reg : i_mode;
        op_fire = (state_reg == RUN) || ((state_reg == IDLE) && !i_start && i_en);
    end

    always_comb begin
        q_next    = q_reg;
        sout_next = sout_reg;
        case (op_mode)
            3'b001: begin q_next = shr_q; sout_next = q_reg[0];       end
            3'b010: begin q_next = shl_q; sout_next = q_reg[WIDTH-1]; end
            3'b011: begin q_next = ror_q; sout_next = q_reg[0];       end
            3'b100: begin q_next = rol_q; sout_next = q_reg[WIDTH-1]; end
            3'b101: q_next = i_d;
            3'b110: begin q_next = asr_q; sout_next = q_reg[0];       end
            3'b111: q_next = '0;
            default: q_next = q_reg;
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_reg <= IDLE;
            mode_reg  <= '0;
            cnt_reg   <= '0;
            q_reg     <= '0;
            sout_reg  <= 1'b0;
            busy_reg  <= 1'b0;
            done_reg  <= 1'b0;
        end else begin
            done_reg <= 1'b0;
            if (op_fire) begin
                q_reg    <= q_next;
                sout_reg <= sout_next;
            end
            case (state_reg)
                IDLE: begin
                    if (i_start) begin
                        mode_reg <= i_mode;
                        cnt_reg  <= i_amt;
                        busy_reg <= 1'b1;
                        if (i_amt == '0) begin
                            state_reg <= DONE;
                            done_reg  <= 1'b1;
                        end else begin
                            state_reg <= RUN;
                        end
                    end
                end
                RUN: begin
                    cnt_reg <= cnt_reg - 1'b1;
                    if (cnt_reg == AMT_W'(1)) begin
                        state_reg <= DONE;
                        done_reg  <= 1'b1;
                    end
                end
                DONE: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
                default: begin
                    state_reg <= IDLE;
                    busy_reg  <= 1'b0;
                end
            endcase
        end
    end

    assign o_q    = q_reg;
    assign o_sout = sout_reg;
    assign o_busy = busy_reg;
    assign o_done = done_reg;

endmodule

// File: doc/universal_shift_reg.md
Name: universal_shift_reg

Overview:
- Parametrised successor to the fixed 4-bit parallel-in/parallel-out register.
- Adds generic width and eight operating modes: hold, shift, rotate, arithmetic shift, parallel load and clear.
- Supports single-step operation, plus a self-timed burst of N operations with a busy/done handshake.
- Used as the general-purpose shift/serialiser primitive across the design.

Parameters:
- WIDTH, 8, data register width in bits (>=2).
- AMT_W, 4, width of burst shift-amount input.

Ports:
- i_clk  in  1  system clock, rising edge.
- i_rst  in  1  synchronous, active-high reset.
- i_en  in  1  single-step enable; honoured only in IDLE.
- i_start  in  1  burst request; honoured only in IDLE.
- i_mode  in  3  operation select.
- i_amt  in  AMT_W  burst operation count; sampled with i_start.
- i_d  in  WIDTH  parallel load data.
- i_sin  in  1  serial input bit; sampled live on every shift.
- o_q  out  WIDTH  register contents, parallel out.
- o_sout  out  1  bit shifted/rotated out by the most recent shift-class op.
- o_busy  out  1  high while state != IDLE.
- o_done  out  1  one-cycle pulse at burst completion.

Behaviour:
- Single clock. Reset is synchronous and active-high, sampled on the rising edge of i_clk.
- Reset values: o_q=0, o_sout=0, o_busy=0, o_done=0, state=IDLE, internal count=0.
- Reset overrides everything, including a burst in progress: the burst is aborted with no o_done.
- Mode encoding (q = o_q):
  - 000 hold: q unchanged.
  - 001 shift right: q<={i_sin,q[W-1:1]}, sout<=q[0].
  - 010 shift left: q<={q[W-2:0],i_sin}, sout<=q[W-1].
  - 011 rotate right: q<={q[0],q[W-1:1]}, sout<=q[0].
  - 100 rotate left: q<={q[W-2:0],q[W-1]}, sout<=q[W-1].
  - 101 parallel load: q<=i_d; sout unchanged.
  - 110 arithmetic shift right: q<={q[W-1],q[W-1:1]}, sout<=q[0].
  - 111 clear: q<=0; sout unchanged.
  - Hold, load and clear never modify o_sout.
- FSM states: IDLE, RUN, DONE.
- IDLE:
  - i_start=1: latch i_mode into mode_r and i_amt into cnt; no op this edge.
    - i_amt==0: go to DONE.
    - otherwise: go to RUN.
  - i_start=0 and i_en=1: perform the i_mode op on this edge; stay in IDLE (latency 1 cycle).
  - i_start and i_en both 1: start wins; no single-step op.
  - Neither asserted: hold.
- RUN:
  - Perform the mode_r op each edge; decrement cnt.
  - When cnt==1 at the edge: perform the final op and go to DONE.
  - i_mode, i_amt, i_start and i_en are ignored; i_sin is still used live.
- DONE: o_done=1 for exactly one cycle, then go to IDLE. i_start/i_en are ignored in this state.
- Burst timing:
  - Start sampled at edge E0; ops occur at E1..EN.
  - o_busy is high from after E0 until after E(N+1).
  - o_done is high in the cycle after EN; the final o_q is valid in that same cycle.
  - Total burst occupancy is N+1 cycles (1 cycle for N=0).
- Boundary conditions:
  - Amount > WIDTH is legal. Shifts keep inserting i_sin (result is fully serial-in); rotates wrap modulo WIDTH.
  - Load or clear in a burst re-applies the same op N times. For load, i_d is sampled live each cycle.
  - Hold in a burst consumes N cycles with no change.
- No combinational input-to-output paths; all outputs are registered.

Test Plan:
- Reset: assert i_rst 2 cycles with i_start=1 -> o_q=0x00, o_busy=0, o_done=0, o_sout=0.
- Single-step:
  - i_en=1, mode=101, i_d=0xB5 -> o_q=0xB5 next cycle.
  - Then mode=001, i_sin=1 -> o_q=0xDA, o_sout=1.
- Rotate-left burst: o_q=0xB5, i_start=1, mode=100, amt=3 -> o_busy high 4 cycles.
  - o_q sequence 0x6B, 0xD6, 0xAD.
  - o_done pulses with o_q=0xAD.
  - i_mode toggled during RUN has no effect.
- Arithmetic shift right burst: o_q=0x96, mode=110, amt=2 -> o_q=0xCB then 0xE5, o_sout=1 at the end.
- Zero amount, and start vs. enable priority:
  - i_start=1, i_en=1, amt=0, mode=010 on o_q=0x3C -> o_q stays 0x3C.
  - o_busy and o_done are high for exactly one cycle, one cycle after the start edge.
- Reset mid-burst: shift-left burst amt=5, i_sin=0 from 0xFF; assert i_rst after 2 ops -> next cycle o_q=0x00, o_busy=0, no o_done pulse ever.
